// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package game_sequencer_pkg;

   localparam int LEVEL_W = 4;
   localparam int LIVES_W = 2;
   localparam int DWELL_W = 16;
   localparam int HIT_W   = 16;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX  = 4'd15;
   localparam logic [LIVES_W-1:0] LIVES_INIT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RESTART,
      S_PLAY,
      S_OVER
   } game_state_e;

   // Dwell shrinks with level but never drops below the floor; the subtraction
   // is guarded so a large level can never wrap around.
   function automatic logic [DWELL_W-1:0] calc_dwell(
      input logic [LEVEL_W-1:0] level,
      input int unsigned        init_ms,
      input int unsigned        step_ms,
      input int unsigned        min_ms
   );
      int unsigned dec;
      int unsigned base;
      dec  = step_ms * {{(32-LEVEL_W){1'b0}}, level};
      base = (dec >= init_ms) ? 32'd0 : (init_ms - dec);
      if (base < min_ms) base = min_ms;
      return base[DWELL_W-1:0];
   endfunction

endpackage

// File: rtl/game_sequencer_dwell_timer.sv
// Millisecond prescaler plus dwell counter; pulses o_expire when the dwell
// limit is reached and restarts from zero.
module dwell_timer
   import game_sequencer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_enable,
   input  logic [DWELL_W-1:0] i_limit,
   output logic               o_expire
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               tick;
   logic               reached;

   always_comb begin
      // NOTE: every output of a comb block gets a default first, so no path can infer a latch.
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      tick     = i_enable && (presc_q == PRESC_LAST);
      reached  = ({1'b0, cnt_q} + (DWELL_W+1)'(1)) >= {1'b0, i_limit};
      o_expire = tick && reached && !i_clear;

      if (i_clear) begin
         presc_d = '0;
         cnt_d   = '0;
      end else if (i_enable) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
         if (tick) cnt_d = reached ? '0 : cnt_q + DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: restart, play, game over, level progression and mole pacing.
// Define GAME_SEQ_LIVES_EN to add a three-life counter that can end the game.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 100000,
   parameter int unsigned DWELL_INIT_MS  = 1500,
   parameter int unsigned DWELL_STEP_MS  = 100,
   parameter int unsigned DWELL_MIN_MS   = 500,
   parameter int unsigned HITS_PER_LEVEL = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_guess_correct,
   input  logic               i_guess_wrong,
   input  logic               i_timer_expired,
   output logic               o_restart_game,
   output logic               o_mole_advance,
   output logic               o_playing,
   output logic               o_game_over,
   output logic [LEVEL_W-1:0] o_level,
   output logic [LIVES_W-1:0] o_lives
);

   game_state_e        state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [HIT_W-1:0]   hits_q, hits_d;
   logic               restart_q, restart_d;
   logic               advance_q, advance_d;
   logic [DWELL_W-1:0] dwell_limit;
   logic               play, active, hit, expire, lives_out;

   // A game-level timeout swallows any hit or dwell expiry in the same cycle.
   assign play        = (state_q == S_PLAY);
   assign active      = play && !i_timer_expired;
   assign hit         = active && i_guess_correct;
   assign dwell_limit = calc_dwell(level_q, DWELL_INIT_MS, DWELL_STEP_MS, DWELL_MIN_MS);

   dwell_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_dwell_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (!play || hit),
      .i_enable (active),
      .i_limit  (dwell_limit),
      .o_expire (expire)
   );

`ifdef GAME_SEQ_LIVES_EN
   logic [LIVES_W-1:0] lives_q, lives_d;

   always_comb begin
      lives_d = lives_q;
      if (state_q == S_RESTART) begin
         lives_d = LIVES_INIT;
      end else if (active && (i_guess_wrong || expire) && (lives_q != '0)) begin
         lives_d = lives_q - LIVES_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lives_q <= '0;
      else      lives_q <= lives_d;
   end

   assign lives_out = play && (lives_q == '0);
   assign o_lives   = lives_q;
`else
   assign lives_out = 1'b0;
   assign o_lives   = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (i_start) state_d = S_RESTART;
         S_RESTART: state_d = S_PLAY;
         S_PLAY:    if (i_timer_expired || lives_out) state_d = S_OVER;
         S_OVER:    if (i_start) state_d = S_RESTART;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_playing   = (state_q == S_PLAY);
      o_game_over = (state_q == S_OVER);
      restart_d   = (state_d == S_RESTART);
      advance_d   = expire;
   end

   always_comb begin
      level_d = level_q;
      hits_d  = hits_q;
      if (state_q == S_RESTART) begin
         level_d = '0;
         hits_d  = '0;
      end else if (hit) begin
         if (({{(32-HIT_W){1'b0}}, hits_q} + 32'd1) >= HITS_PER_LEVEL) begin
            hits_d = '0;
            if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
         end else begin
            hits_d = hits_q + HIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q   <= '0;
         hits_q    <= '0;
         restart_q <= 1'b0;
         advance_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         hits_q    <= hits_d;
         restart_q <= restart_d;
         advance_q <= advance_d;
      end
   end

   assign o_restart_game = restart_q;
   assign o_mole_advance = advance_q;
   assign o_level        = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: cycle-level reference model plus directed checks.
module tb_game_sequencer;

   localparam int TICK_DIV       = 4;
   localparam int DWELL_INIT_MS  = 10;
   localparam int DWELL_STEP_MS  = 2;
   localparam int DWELL_MIN_MS   = 4;
   localparam int HITS_PER_LEVEL = 2;
`ifdef GAME_SEQ_LIVES_EN
   localparam int START_LIVES = 3;
`else
   localparam int START_LIVES = 0;
`endif

   localparam int M_IDLE = 0, M_RESTART = 1, M_PLAY = 2, M_OVER = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_start = 1'b0;
   logic       i_guess_correct = 1'b0;
   logic       i_guess_wrong = 1'b0;
   logic       i_timer_expired = 1'b0;
   logic       o_restart_game, o_mole_advance, o_playing, o_game_over;
   logic [3:0] o_level;
   logic [1:0] o_lives;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   // Reference model state: game phase, level, hits, cycles elapsed in the current mole window.
   int m_st = M_IDLE, m_level = 0, m_hits = 0, m_win = 0, m_lives = 0;
   int m_adv = 0, m_rp = 0;

   game_sequencer #(
      .TICK_DIV       (TICK_DIV),
      .DWELL_INIT_MS  (DWELL_INIT_MS),
      .DWELL_STEP_MS  (DWELL_STEP_MS),
      .DWELL_MIN_MS   (DWELL_MIN_MS),
      .HITS_PER_LEVEL (HITS_PER_LEVEL)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_start         (i_start),
      .i_guess_correct (i_guess_correct),
      .i_guess_wrong   (i_guess_wrong),
      .i_timer_expired (i_timer_expired),
      .o_restart_game  (o_restart_game),
      .o_mole_advance  (o_mole_advance),
      .o_playing       (o_playing),
      .o_game_over     (o_game_over),
      .o_level         (o_level),
      .o_lives         (o_lives)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int dwell_ms(input int lvl);
      int d;
      d = DWELL_INIT_MS - lvl * DWELL_STEP_MS;
      return (d < DWELL_MIN_MS) ? DWELL_MIN_MS : d;
   endfunction

   // Model: a mole window lasts TICK_DIV * dwell(level) play cycles.
   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_st = M_IDLE; m_level = 0; m_hits = 0; m_win = 0;
         m_lives = 0; m_adv = 0; m_rp = 0;
      end else begin
         int  lose;
         int  end_play;
         m_adv = 0;
         case (m_st)
            M_IDLE, M_OVER: if (i_start) m_st = M_RESTART;
            M_RESTART: begin
               m_level = 0; m_hits = 0; m_win = 0; m_lives = START_LIVES;
               m_st = M_PLAY;
            end
            default: begin
               if (i_timer_expired) begin
                  m_st = M_OVER;
               end else begin
                  lose     = 0;
                  end_play = (START_LIVES != 0) && (m_lives == 0);
                  if (i_guess_correct) begin
                     m_win  = 0;
                     m_hits = m_hits + 1;
                     if (m_hits == HITS_PER_LEVEL) begin
                        m_hits  = 0;
                        m_level = (m_level < 15) ? m_level + 1 : 15;
                     end
                  end else begin
                     m_win = m_win + 1;
                     if (m_win >= TICK_DIV * dwell_ms(m_level)) begin
                        m_adv = 1;
                        m_win = 0;
                        lose  = 1;
                     end
                  end
                  if (i_guess_wrong) lose = 1;
                  if (START_LIVES != 0 && lose != 0 && m_lives > 0) m_lives = m_lives - 1;
                  if (end_play != 0) m_st = M_OVER;
               end
            end
         endcase
         m_rp = (m_st == M_RESTART) ? 1 : 0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("model_restart", int'(o_restart_game), m_rp);
         check("model_advance", int'(o_mole_advance), m_adv);
         check("model_playing", int'(o_playing), (m_st == M_PLAY) ? 1 : 0);
         check("model_game_over", int'(o_game_over), (m_st == M_OVER) ? 1 : 0);
         check("model_level", int'(o_level), m_level);
         check("model_lives", int'(o_lives), m_lives);
      end
   end

   task automatic wait_adv(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (o_mole_advance !== 1'b1 && cyc < 200);
      check("advance_seen", int'(o_mole_advance), 1);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic pulse_correct(input int gap);
      i_guess_correct = 1'b1;
      @(negedge clk);
      i_guess_correct = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      int c;
      repeat (3) @(negedge clk);
      rst    = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_playing", int'(o_playing), 0);
      check("rst_game_over", int'(o_game_over), 0);
      check("rst_level", int'(o_level), 0);
      check("rst_lives", int'(o_lives), 0);
      check("rst_restart", int'(o_restart_game), 0);

      pulse_start();
      check("restart_pulse", int'(o_restart_game), 1);
      check("restart_not_playing", int'(o_playing), 0);
      @(negedge clk);
      check("restart_one_cycle", int'(o_restart_game), 0);
      check("play_entry", int'(o_playing), 1);
      check("level_after_start", int'(o_level), 0);

      wait_adv(c);
      wait_adv(c);
      check("period_level0", c, 40);
      wait_adv(c);
      check("period_level0_again", c, 40);

      repeat (6) pulse_correct(2);
      check("level_after_six_hits", int'(o_level), 3);
      wait_adv(c);
      wait_adv(c);
      check("period_level3", c, 16);

      repeat (2) pulse_correct(2);
      check("level_after_eight_hits", int'(o_level), 4);
      wait_adv(c);
      wait_adv(c);
      check("period_level4_floor", c, 16);

      // Land a hit on the exact cycle the dwell window would expire.
      repeat (15) @(negedge clk);
      pulse_correct(0);
      check("coincide_no_advance", int'(o_mole_advance), 0);
      wait_adv(c);
      check("coincide_window_restart", c, 16);

      i_timer_expired = 1'b1;
      i_guess_correct = 1'b1;
      @(negedge clk);
      i_timer_expired = 1'b0;
      i_guess_correct = 1'b0;
      check("game_over_flag", int'(o_game_over), 1);
      check("game_over_not_playing", int'(o_playing), 0);
      check("game_over_hit_ignored", int'(o_level), 4);
      @(negedge clk);
      check("game_over_holds", int'(o_game_over), 1);

      pulse_start();
      check("restart_from_over", int'(o_restart_game), 1);
      @(negedge clk);
      check("replay_playing", int'(o_playing), 1);
      check("replay_level_cleared", int'(o_level), 0);
      check("replay_over_cleared", int'(o_game_over), 0);

      pulse_start();
      check("start_ignored_in_play", int'(o_restart_game), 0);
      check("still_playing", int'(o_playing), 1);

      repeat (10) @(negedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      check("midplay_rst_playing", int'(o_playing), 0);
      check("midplay_rst_advance", int'(o_mole_advance), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_release", int'(o_playing), 0);
      check("idle_no_restart", int'(o_restart_game), 0);

`ifdef GAME_SEQ_LIVES_EN
      pulse_start();
      @(negedge clk);
      check("lives_loaded", int'(o_lives), 3);
      repeat (39) @(negedge clk);
      i_guess_wrong = 1'b1;
      @(negedge clk);
      i_guess_wrong = 1'b0;
      check("wrong_with_expiry_one_life", int'(o_lives), 2);
      check("expiry_still_advances", int'(o_mole_advance), 1);
      i_guess_wrong = 1'b1;
      @(negedge clk);
      i_guess_wrong = 1'b0;
      check("lives_after_wrong2", int'(o_lives), 1);
      i_guess_wrong = 1'b1;
      @(negedge clk);
      i_guess_wrong = 1'b0;
      check("lives_after_wrong3", int'(o_lives), 0);
      check("still_playing_at_zero", int'(o_playing), 1);
      @(negedge clk);
      check("over_after_last_life", int'(o_game_over), 1);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000: clk cycles per 1 ms tick.
REQ-002 SHALL have parameter DWELL_INIT_MS, default 1500: mole dwell at level 0.
REQ-003 SHALL have parameter DWELL_STEP_MS, default 100: dwell reduction per level.
REQ-004 SHALL have parameter DWELL_MIN_MS, default 500: dwell floor.
REQ-005 SHALL have parameter HITS_PER_LEVEL, default 5: correct hits per level-up.
REQ-006 SHALL have port clk, input, 1: system clock.
REQ-007 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port i_start, input, 1: single-cycle start/restart request.
REQ-009 SHALL have ports i_guess_correct and i_guess_wrong, input, 1 each: single-cycle evaluation results.
REQ-010 SHALL have port i_timer_expired, input, 1: level, countdown reached zero.
REQ-011 SHALL have port o_restart_game, output, 1: single-cycle restart pulse to game datapath.
REQ-012 SHALL have port o_mole_advance, output, 1: single-cycle request to move mole.
REQ-013 SHALL have ports o_playing and o_game_over, output, 1 each: state flags.
REQ-014 SHALL have port o_level, output, 4: current difficulty level.
REQ-015 SHALL have port o_lives, output, 2: remaining lives (LIVES_EN only; else constant 0).

Function
REQ-016 FSM states SHALL be IDLE, RESTART, PLAY, OVER.
REQ-017 IDLE or OVER with i_start SHALL go to RESTART; i_start in RESTART/PLAY ignored.
REQ-018 RESTART SHALL last exactly one cycle, assert o_restart_game, clear level, hit count, dwell counter, reload lives, then enter PLAY.
REQ-019 PLAY with i_timer_expired SHALL enter OVER next cycle; any hit/timeout that cycle discarded.
REQ-020 o_playing SHALL be 1 only in PLAY; o_game_over 1 only in OVER.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 in PLAY only, emitting one tick per wrap; cleared outside PLAY.
REQ-022 Dwell counter (16 bits) SHALL increment per tick in PLAY; reaching current dwell SHALL pulse o_mole_advance one cycle and clear counter.
REQ-023 Current dwell SHALL be max(DWELL_INIT_MS - o_level*DWELL_STEP_MS, DWELL_MIN_MS), computed without underflow.
REQ-024 i_guess_correct in PLAY SHALL clear dwell counter and prescaler and increment hit count; no o_mole_advance that cycle.
REQ-025 Hit count reaching HITS_PER_LEVEL SHALL clear to 0 and increment o_level, saturating at 15.
REQ-026 Correct and dwell expiry in same cycle: correct wins, no advance pulse.
REQ-027 o_mole_advance and o_restart_game SHALL be registered outputs, never asserted together.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, all counters 0, o_level 0, o_lives 0, all pulses/flags 0.
REQ-029 Reset mid-PLAY SHALL abort without o_mole_advance; release returns to IDLE awaiting i_start.

Configuration
REQ-030 Macro GAME_SEQ_LIVES_EN defined: RESTART SHALL load o_lives=3; in PLAY each i_guess_wrong or dwell expiry SHALL decrement o_lives; reaching 0 SHALL enter OVER next cycle (dwell expiry still pulses o_mole_advance).
REQ-031 Wrong guess and dwell expiry same cycle SHALL cost one life only.
REQ-032 Macro undefined: no lives logic; o_lives tied 0; only i_timer_expired ends PLAY.

Structure
REQ-033 State encoding typedef and level/lives width constants SHALL live in the shared game package.
REQ-034 Prescaler plus dwell counter SHALL be one sub-module, dwell_timer (inputs: clear, enable, limit; output: expire pulse).

Verification (sim params TICK_DIV=4, DWELL_INIT_MS=10, DWELL_STEP_MS=2, DWELL_MIN_MS=4, HITS_PER_LEVEL=2)
REQ-035 Reset release, pulse i_start -> o_restart_game high exactly one cycle, o_playing high next cycle, o_level=0.
REQ-036 No guesses in PLAY -> o_mole_advance every 40 cycles, one cycle wide.
REQ-037 Six i_guess_correct pulses -> o_level=3, advance period 16 cycles (dwell floor 4 ms); further hits keep 16.
REQ-038 i_guess_correct coincident with dwell expiry -> no o_mole_advance, counter restarts from 0.
REQ-039 i_timer_expired high in PLAY -> o_game_over next cycle, i_guess_correct ignored; i_start then -> RESTART, o_level=0.
REQ-040 With GAME_SEQ_LIVES_EN: three i_guess_wrong -> o_lives 3,2,1,0, then OVER; wrong+expiry same cycle decrements once.
